// File: rtl/imem_fill_responder.sv
// Instruction-fill responder: accepts a line request, waits READ_LATENCY cycles, streams LINE_WORDS beats.
// Request to first beat: READ_LATENCY+1 cycles; beats are held stable while resp_ready is low.
module imem_fill_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int LINE_WORDS   = 4,
    parameter int READ_LATENCY = 2,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_last,
    output logic          resp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LNW = AW - OW;
    localparam logic [3:0] LAT = 4'(READ_LATENCY);
    localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t state, state_n;

    logic [31:0]    mem [MEM_WORDS];
    logic [3:0]     cnt;
    logic [OW-1:0]  beat;
    logic [LNW-1:0] line_q;
    logic           err_q;

    logic           accept;
    logic           hs;
    logic           oor;
    logic [LNW-1:0] req_line;
    logic           fetch;
    logic [LNW-1:0] fetch_line;
    logic [OW-1:0]  fetch_beat;
    logic           fetch_err;
    logic           unused_addr_bits;

    assign accept   = req_valid && req_ready;
    assign hs       = resp_valid && resp_ready;
    // Full-width range check so huge addresses never alias into the array.
    assign oor      = {2'b00, req_addr[63:2]} >= 64'(MEM_WORDS);
    assign req_line = req_addr[AW+1:OW+2];
    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        state_n    = state;
        fetch      = 1'b0;
        fetch_line = line_q;
        fetch_beat = beat;
        fetch_err  = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LAT == 4'd0) begin
                        state_n    = BURST;
                        fetch      = 1'b1;
                        fetch_line = req_line;
                        fetch_beat = '0;
                        fetch_err  = oor;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_n    = BURST;
                    fetch      = 1'b1;
                    fetch_beat = '0;
                end
            end
            BURST: begin
                if (hs) begin
                    if (beat == LAST) begin
                        state_n = IDLE;
                    end else begin
                        fetch      = 1'b1;
                        fetch_beat = beat + OW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            cnt        <= '0;
            beat       <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == IDLE);
            if (state == IDLE && accept) begin
                line_q <= req_line;
                err_q  <= oor;
                cnt    <= LAT;
                beat   <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (fetch) begin
                beat       <= fetch_beat;
                resp_valid <= 1'b1;
                resp_data  <= fetch_err ? 32'h0 : mem[{fetch_line, fetch_beat}];
                resp_last  <= (fetch_beat == LAST);
                resp_err   <= fetch_err;
            end else if (state == BURST && hs) begin
                resp_valid <= 1'b0;
                resp_last  <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Loads are honoured regardless of reset so the store can be filled while the core is held.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end
endmodule

// File: tb/tb_imem_fill_responder.sv
// Randomized scoreboard bench for imem_fill_responder against a line-level reference model.
module tb_imem_fill_responder;
    localparam int MW  = 1024;
    localparam int LW  = 4;
    localparam int LAT = 2;
    localparam int AW  = $clog2(MW);

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [63:0]   req_addr = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_data;
    logic          resp_last;
    logic          resp_err;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    imem_fill_responder #(.MEM_WORDS(MW), .LINE_WORDS(LW), .READ_LATENCY(LAT)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        e;
    } beat_t;

    logic [31:0] ref_mem [MW];
    beat_t exp_q [$];
    int    lat_q [$];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    n_accept = 0;
    int    acc_cyc = 0;
    int    last_hs_cyc = 0;
    int    beats = 0;
    bit    busy = 1'b0;
    bit    rst_q = 1'b1;
    int    rr_mode = 0;
    int    stall_cnt = 0;
    bit    stalled = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a whole line is predicted at the moment the request is accepted.
    always @(posedge CLK) begin
        cyc++;
        if (!reset && req_valid && req_ready) begin
            longint unsigned w;
            longint unsigned base;
            bit o;
            w    = req_addr >> 2;
            o    = (w >= MW);
            base = w - (w % LW);
            for (int i = 0; i < LW; i++) begin
                beat_t b;
                b.d = o ? 32'h0 : ref_mem[int'(base) + i];
                b.l = (i == LW - 1);
                b.e = o;
                exp_q.push_back(b);
            end
            lat_q.push_back(cyc + LAT);
            busy = 1'b1;
            n_accept++;
            acc_cyc = cyc;
        end
        rst_q = reset;
    end

    logic [31:0] prev_d;
    logic        prev_l, prev_e, prev_stall = 1'b0;

    always @(negedge CLK) begin
        if (!reset && !rst_q) begin
            chk("req_ready", {63'b0, req_ready}, {63'b0, !busy});
            if (!busy) chk("valid_idle", {63'b0, resp_valid}, 64'd0);
            else if (beats == 0 && lat_q.size() > 0)
                chk("first_beat_timing", {63'b0, resp_valid}, {63'b0, cyc >= lat_q[0]});
            else chk("valid_in_burst", {63'b0, resp_valid}, 64'd1);
            if (prev_stall) begin
                chk("stall_data", {32'b0, resp_data}, {32'b0, prev_d});
                chk("stall_last_err", {62'b0, resp_last, resp_err}, {62'b0, prev_l, prev_e});
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", {32'b0, resp_data}, {32'b0, b.d});
                    chk("beat_last_err", {62'b0, resp_last, resp_err}, {62'b0, b.l, b.e});
                    if (b.l) begin
                        busy = 1'b0;
                        beats = 0;
                        last_hs_cyc = cyc;
                        if (lat_q.size() > 0) void'(lat_q.pop_front());
                    end else begin
                        beats++;
                    end
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_d = resp_data;
            prev_l = resp_last;
            prev_e = resp_err;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // resp_ready policy: 0 always ready, 1 random, 2 one 5-cycle stall on beat 1, 3 held low.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rr_mode)
                0: resp_ready = 1'b1;
                1: resp_ready = ($urandom_range(3) != 0);
                2: begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                        resp_ready = 1'b0;
                    end else if (beats == 1 && busy && !stalled) begin
                        stalled = 1'b1;
                        stall_cnt = 4;
                        resp_ready = 1'b0;
                    end else resp_ready = 1'b1;
                end
                default: resp_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        ref_mem[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic request(input logic [63:0] a);
        int na;
        int i;
        na = n_accept;
        req_valid = 1'b1;
        req_addr = a;
        for (i = 0; i < 200 && n_accept == na; i++) tick();
        if (n_accept == na) chk("accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && (busy || exp_q.size() != 0); i++) tick();
        if (busy || exp_q.size() != 0) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int na;
        int hs_ref;
        // Whole store preloaded while reset is held.
        load(0, 32'h0050_0093);
        load(1, 32'h1);
        load(2, 32'h2);
        load(3, 32'h3);
        for (int i = 4; i < MW; i++) load(i, $urandom);
        reset = 1'b1;
        tick();
        chk("rst_req_ready", {63'b0, req_ready}, 64'd0);
        chk("rst_outputs", {29'b0, resp_valid, resp_last, resp_err, resp_data}, 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {63'b0, req_ready}, 64'd1);

        // 1, 2: basic line fetches
        rr_mode = 0;
        request(64'h0);
        wait_idle();
        request(64'h1C);
        wait_idle();

        // 3: backpressure on beat 1
        rr_mode = 2;
        stalled = 1'b0;
        request(64'h40);
        wait_idle();
        chk("stall_taken", {63'b0, stalled}, 64'd1);
        rr_mode = 0;

        // 4: out-of-range lines, then a normal one; also the last in-range line
        request(64'(MW * 4));
        wait_idle();
        request(64'hFFFF_0000_0000_0000);
        wait_idle();
        request(64'(MW * 4 - 4));
        wait_idle();
        request(64'h84);
        wait_idle();

        // 5: back-to-back with req_valid held high
        na = n_accept;
        req_valid = 1'b1;
        req_addr = 64'h20;
        for (int i = 0; i < 200 && n_accept < na + 1; i++) tick();
        req_addr = 64'h30;
        for (int i = 0; i < 200 && n_accept < na + 2; i++) tick();
        req_valid = 1'b0;
        chk("b2b_accepts", 64'(n_accept - na), 64'd2);
        chk("b2b_timing", 64'(acc_cyc), 64'(last_hs_cyc + 2));
        wait_idle();

        // 6: reset while beat 2 is on the bus
        request(64'h0);
        hs_ref = 0;
        while (beats != 2 && hs_ref < 100) begin
            tick();
            hs_ref++;
        end
        chk("reached_beat2", 64'(beats), 64'd2);
        rr_mode = 3;
        resp_ready = 1'b0;
        reset = 1'b1;
        tick();
        exp_q.delete();
        lat_q.delete();
        busy = 1'b0;
        beats = 0;
        chk("rst_abort_valid", {63'b0, resp_valid}, 64'd0);
        tick();
        reset = 1'b0;
        rr_mode = 0;
        tick();
        chk("rst_ready_after", {63'b0, req_ready}, 64'd1);
        request(64'h0);
        wait_idle();

        // Randomized traffic with random backpressure and idle-time loads
        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            if ($urandom_range(7) == 0) a = {$urandom, $urandom} | 64'h1_0000;
            else a = 64'($urandom_range(MW * 4 - 1));
            if ($urandom_range(2) == 0) load($urandom_range(MW - 1), $urandom);
            request(a);
            wait_idle();
        end
        rr_mode = 0;
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
